xyolo_write_ctrl: RTL and testbench

- Internal sequencer for the YOLO write stage: generates the "B"-side controls that the external address generators do not.
- After the vread tile is loaded, walks the pixel memory once per output pixel and issues read enables/addresses.
- Drives the xyolo load strobes (ld_acc, ld_nmac, ld_mp, ld_res), aligned to the pixel pipeline.
- Schedules the vwrite memory writes after the xyolo result latency, then raises done.

---
 rtl/xyolo_write_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_xyolo_write_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/xyolo_write_ctrl.sv
// Write-stage sequencer for xyolo: pixel read walk, load strobes and vwrite scheduling.
// Optional XYOLO_WRITE_CTRL_PERF_EN adds a busy-cycle counter output perf_cycles.
module xyolo_write_ctrl #(
   parameter int N_MACS    = 8,
   parameter int N_MACS_W  = $clog2(N_MACS),
   parameter int N_VECT    = 16,
   parameter int RD_ADDR_W = 10,
   parameter int WR_ADDR_W = 9,
   parameter int CNT_W     = 16,
   parameter int RD_LAT    = 2,
   parameter int RES_LAT   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   output logic                 done,
   input  logic [CNT_W-1:0]     cfg_n_out,
   input  logic [CNT_W-1:0]     cfg_n_acc,
   input  logic [N_MACS_W-1:0]  cfg_last_nmac,
   input  logic [RD_ADDR_W-1:0] cfg_rd_start,
   input  logic [RD_ADDR_W-1:0] cfg_rd_stride,
   input  logic [WR_ADDR_W-1:0] cfg_wr_start,
   input  logic [N_VECT-1:0]    cfg_wr_mask,
   input  logic                 cfg_mp,
   output logic                 vread_enB,
   output logic [RD_ADDR_W-1:0] vread_addrB,
   output logic                 ld_acc,
   output logic [N_MACS_W-1:0]  ld_nmac,
   output logic                 ld_mp,
   output logic                 ld_res,
   output logic [N_VECT-1:0]    vwrite_enB,
   output logic [WR_ADDR_W-1:0] vwrite_addrB
`ifdef XYOLO_WRITE_CTRL_PERF_EN
   ,
   output logic [31:0]          perf_cycles
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH} state_t;

   state_t               state, state_nx;
   logic                 start;
   logic [CNT_W-1:0]     n_out_q, n_acc_q;
   logic [N_MACS_W-1:0]  last_nmac_q;
   logic [RD_ADDR_W-1:0] stride_q;
   logic [N_VECT-1:0]    mask_q;
   logic                 mp_q;
   logic [CNT_W-1:0]     acc_cnt, out_cnt;
   logic [RD_ADDR_W-1:0] base_q;
   logic [WR_ADDR_W-1:0] wr_addr;
   logic                 acc_last, out_last, pending;

   logic                 vld_p0, first_p0, last_p0, fin_p0;
   logic [1:0]           grp_p0;
   logic [RD_LAT-1:0]    vld_pl, first_pl, last_pl, fin_pl;
   logic [1:0]           grp_pl [RD_LAT];
   logic                 wr_p0;
   logic [RES_LAT-1:0]   wr_pl;

   assign start    = (state == S_IDLE) && run;
   assign acc_last = (acc_cnt == n_acc_q - CNT_W'(1));
   assign out_last = (out_cnt == n_out_q - CNT_W'(1));
   // The last write stage is the current write; only earlier stages hold future work.
   assign pending  = (|vld_pl) | (|wr_pl[RES_LAT-2:0]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (run) state_nx = (cfg_n_out == '0 || cfg_n_acc == '0) ? S_FLUSH : S_ISSUE;
         S_ISSUE: if (acc_last && out_last) state_nx = S_FLUSH;
         S_FLUSH: if (!pending) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Configuration is captured only when a run is accepted, so it needs no reset.
   always_ff @(posedge clk) begin
      if (start) begin
         n_out_q     <= cfg_n_out;
         n_acc_q     <= cfg_n_acc;
         last_nmac_q <= cfg_last_nmac;
         stride_q    <= cfg_rd_stride;
         mask_q      <= cfg_wr_mask;
         mp_q        <= cfg_mp;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_cnt <= '0;
         out_cnt <= '0;
         base_q  <= '0;
      end else if (start) begin
         acc_cnt <= '0;
         out_cnt <= '0;
         base_q  <= cfg_rd_start;
      end else if (state == S_ISSUE) begin
         if (acc_last) begin
            acc_cnt <= '0;
            out_cnt <= out_cnt + CNT_W'(1);
            base_q  <= base_q + stride_q;
         end else begin
            acc_cnt <= acc_cnt + CNT_W'(1);
         end
      end
   end

   // Stage 0: tags of the read issued this cycle
   always_comb begin
      vld_p0   = (state == S_ISSUE);
      first_p0 = vld_p0 && (acc_cnt == '0);
      last_p0  = vld_p0 && acc_last;
      fin_p0   = vld_p0 && out_last;
      grp_p0   = out_cnt[1:0];
   end

   // Stages 1..RD_LAT: tags travel with the word through the read latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pl   <= '0;
         first_pl <= '0;
         last_pl  <= '0;
         fin_pl   <= '0;
         for (int i = 0; i < RD_LAT; i++) grp_pl[i] <= '0;
      end else begin
         for (int i = RD_LAT-1; i > 0; i--) begin
            vld_pl[i]   <= vld_pl[i-1];
            first_pl[i] <= first_pl[i-1];
            last_pl[i]  <= last_pl[i-1];
            fin_pl[i]   <= fin_pl[i-1];
            grp_pl[i]   <= grp_pl[i-1];
         end
         vld_pl[0]   <= vld_p0;
         first_pl[0] <= first_p0;
         last_pl[0]  <= last_p0;
         fin_pl[0]   <= fin_p0;
         grp_pl[0]   <= grp_p0;
      end
   end

   // A partial trailing maxpool group still writes at its final output.
   assign wr_p0 = last_pl[RD_LAT-1] &&
                  (!mp_q || grp_pl[RD_LAT-1] == 2'd3 || fin_pl[RD_LAT-1]);

   // Result latency stages: write request waits for xyolo output data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_pl   <= '0;
         wr_addr <= '0;
      end else begin
         wr_pl <= {wr_pl[RES_LAT-2:0], wr_p0};
         if (start)                  wr_addr <= cfg_wr_start;
         else if (wr_pl[RES_LAT-1]) wr_addr <= wr_addr + WR_ADDR_W'(1);
      end
   end

   always_comb begin
      done         = (state == S_IDLE);
      vread_enB    = (state == S_ISSUE);
      vread_addrB  = base_q + acc_cnt[RD_ADDR_W-1:0];
      ld_acc       = first_pl[RD_LAT-1];
      ld_res       = last_pl[RD_LAT-1];
      ld_mp        = mp_q && last_pl[RD_LAT-1] && (grp_pl[RD_LAT-1] == 2'd0);
      ld_nmac      = '0;
      if (vld_pl[RD_LAT-1])
         ld_nmac = last_pl[RD_LAT-1] ? last_nmac_q : N_MACS_W'(N_MACS-1);
      vwrite_enB   = wr_pl[RES_LAT-1] ? mask_q : '0;
      vwrite_addrB = wr_addr;
   end

`ifdef XYOLO_WRITE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   perf_cycles <= '0;
      else if (start)                             perf_cycles <= '0;
      else if (state != S_IDLE && ~&perf_cycles)  perf_cycles <= perf_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_xyolo_write_ctrl.sv
// Directed self-checking bench for xyolo_write_ctrl with hand-derived cycle timing.
module tb_xyolo_write_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic        done;
   logic [15:0] cfg_n_out, cfg_n_acc;
   logic [2:0]  cfg_last_nmac;
   logic [9:0]  cfg_rd_start, cfg_rd_stride;
   logic [8:0]  cfg_wr_start;
   logic [15:0] cfg_wr_mask;
   logic        cfg_mp;
   logic        vread_enB;
   logic [9:0]  vread_addrB;
   logic        ld_acc, ld_mp, ld_res;
   logic [2:0]  ld_nmac;
   logic [15:0] vwrite_enB;
   logic [8:0]  vwrite_addrB;
`ifdef XYOLO_WRITE_CTRL_PERF_EN
   logic [31:0] perf_cycles;
`endif

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic        cap_en   [64];
   logic [9:0]  cap_ra   [64];
   logic        cap_acc  [64];
   logic        cap_res  [64];
   logic        cap_mp   [64];
   logic [2:0]  cap_nmac [64];
   logic [15:0] cap_wen  [64];
   logic [8:0]  cap_wa   [64];
   logic        cap_done [64];

   always #5 clk = ~clk;

   xyolo_write_ctrl dut (
      .clk(clk), .rst(rst), .run(run), .done(done),
      .cfg_n_out(cfg_n_out), .cfg_n_acc(cfg_n_acc), .cfg_last_nmac(cfg_last_nmac),
      .cfg_rd_start(cfg_rd_start), .cfg_rd_stride(cfg_rd_stride),
      .cfg_wr_start(cfg_wr_start), .cfg_wr_mask(cfg_wr_mask), .cfg_mp(cfg_mp),
      .vread_enB(vread_enB), .vread_addrB(vread_addrB),
      .ld_acc(ld_acc), .ld_nmac(ld_nmac), .ld_mp(ld_mp), .ld_res(ld_res),
      .vwrite_enB(vwrite_enB), .vwrite_addrB(vwrite_addrB)
`ifdef XYOLO_WRITE_CTRL_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [15:0] n_out, input logic [15:0] n_acc,
                          input logic [2:0] last, input logic [9:0] rs, input logic [9:0] st,
                          input logic [8:0] ws, input logic [15:0] mask, input logic mp);
      cfg_n_out = n_out; cfg_n_acc = n_acc; cfg_last_nmac = last;
      cfg_rd_start = rs; cfg_rd_stride = st; cfg_wr_start = ws;
      cfg_wr_mask = mask; cfg_mp = mp;
   endtask

   // Caller raises run at a negedge; cycle c is the interval after edge c-1.
   // Extra run pulses are sampled at edges ra and rb (0 = none).
   task automatic capture(input int n, input int ra, input int rb);
      for (int c = 1; c <= n; c++) begin
         @(posedge clk);
         #1;
         run = (c == ra || c == rb);
         if (run) begin
            cfg_n_out = 16'd9; cfg_rd_start = 10'h155; cfg_wr_start = 9'h0AA;
         end
         @(negedge clk);
         cap_en[c] = vread_enB;  cap_ra[c]  = vread_addrB;
         cap_acc[c] = ld_acc;    cap_res[c] = ld_res;   cap_mp[c] = ld_mp;
         cap_nmac[c] = ld_nmac;  cap_wen[c] = vwrite_enB;
         cap_wa[c] = vwrite_addrB; cap_done[c] = done;
      end
      run = 1'b0;
   endtask

   task automatic check_basic(input string p);
      for (int c = 1; c <= 14; c++) begin
         chk($sformatf("%s en c%0d", p, c), cap_en[c], (c <= 6));
         if (c <= 3) chk($sformatf("%s raddr c%0d", p, c), cap_ra[c], 10'h10 + 10'(c - 1));
         else if (c <= 6) chk($sformatf("%s raddr c%0d", p, c), cap_ra[c], 10'h30 + 10'(c - 4));
         chk($sformatf("%s ld_acc c%0d", p, c), cap_acc[c], (c == 3 || c == 6));
         chk($sformatf("%s ld_res c%0d", p, c), cap_res[c], (c == 5 || c == 8));
         chk($sformatf("%s ld_mp c%0d", p, c), cap_mp[c], 1'b0);
         if (c >= 3 && c <= 8)
            chk($sformatf("%s ld_nmac c%0d", p, c), cap_nmac[c], (c == 5 || c == 8) ? 3 : 7);
         chk($sformatf("%s wen c%0d", p, c), cap_wen[c], (c == 8 || c == 11) ? 16'hFFFF : 16'h0);
         if (c == 8)  chk($sformatf("%s waddr c%0d", p, c), cap_wa[c], 9'd5);
         if (c == 11) chk($sformatf("%s waddr c%0d", p, c), cap_wa[c], 9'd6);
         chk($sformatf("%s done c%0d", p, c), cap_done[c], (c >= 12));
      end
   endtask

   task automatic check_idle_outputs(input string p);
      chk({p, " done"}, done, 1'b1);
      chk({p, " en"}, vread_enB, 1'b0);
      chk({p, " raddr"}, vread_addrB, 10'h0);
      chk({p, " strobes"}, {ld_acc, ld_res, ld_mp}, 3'b000);
      chk({p, " nmac"}, ld_nmac, 3'd0);
      chk({p, " wen"}, vwrite_enB, 16'h0);
      chk({p, " waddr"}, vwrite_addrB, 9'h0);
   endtask

   initial begin
      set_cfg(16'd0, 16'd0, 3'd0, 10'h0, 10'h0, 9'h0, 16'h0, 1'b0);
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic run
      set_cfg(16'd2, 16'd3, 3'd3, 10'h10, 10'h20, 9'd5, 16'hFFFF, 1'b0);
      run = 1'b1;
      capture(14, 0, 0);
      check_basic("basic");
`ifdef XYOLO_WRITE_CTRL_PERF_EN
      chk("perf_cycles", perf_cycles, 32'd11);
`endif

      // Maxpool: 6 outputs, one word each
      set_cfg(16'd6, 16'd1, 3'd4, 10'h0, 10'h1, 9'h20, 16'h0003, 1'b1);
      @(negedge clk);
      run = 1'b1;
      capture(14, 0, 0);
      begin
         int nwr = 0;
         for (int c = 1; c <= 14; c++) begin
            if (cap_wen[c] != 16'h0) nwr++;
            chk($sformatf("mp en c%0d", c), cap_en[c], (c <= 6));
            if (c <= 6) chk($sformatf("mp raddr c%0d", c), cap_ra[c], 10'(c - 1));
            chk($sformatf("mp ld_res c%0d", c), cap_res[c], (c >= 3 && c <= 8));
            chk($sformatf("mp ld_acc c%0d", c), cap_acc[c], (c >= 3 && c <= 8));
            chk($sformatf("mp ld_mp c%0d", c), cap_mp[c], (c == 3 || c == 7));
            if (c >= 3 && c <= 8) chk($sformatf("mp ld_nmac c%0d", c), cap_nmac[c], 3'd4);
            chk($sformatf("mp wen c%0d", c), cap_wen[c], (c == 9 || c == 11) ? 16'h0003 : 16'h0);
            chk($sformatf("mp done c%0d", c), cap_done[c], (c >= 12));
         end
         chk("mp waddr first", cap_wa[9], 9'h20);
         chk("mp waddr second", cap_wa[11], 9'h21);
         chk("mp write count", nwr, 2);
      end

      // Zero work
      set_cfg(16'd0, 16'd4, 3'd1, 10'h33, 10'h1, 9'h3, 16'hFFFF, 1'b0);
      @(negedge clk);
      run = 1'b1;
      capture(6, 0, 0);
      for (int c = 1; c <= 6; c++) begin
         chk($sformatf("zero en c%0d", c), cap_en[c], 1'b0);
         chk($sformatf("zero strobes c%0d", c), {cap_acc[c], cap_res[c], cap_mp[c]}, 3'b000);
         chk($sformatf("zero wen c%0d", c), cap_wen[c], 16'h0);
         chk($sformatf("zero done c%0d", c), cap_done[c], (c != 1));
      end

      // Address wrap-around
      set_cfg(16'd2, 16'd4, 3'd5, 10'h3FE, 10'h4, 9'h1FF, 16'h8001, 1'b0);
      @(negedge clk);
      run = 1'b1;
      capture(16, 0, 0);
      begin
         logic [9:0] exp_ra [8] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001,
                                    10'h002, 10'h003, 10'h004, 10'h005};
         for (int c = 1; c <= 16; c++) begin
            chk($sformatf("wrap en c%0d", c), cap_en[c], (c <= 8));
            if (c <= 8) chk($sformatf("wrap raddr c%0d", c), cap_ra[c], exp_ra[c-1]);
            chk($sformatf("wrap ld_acc c%0d", c), cap_acc[c], (c == 3 || c == 7));
            chk($sformatf("wrap ld_res c%0d", c), cap_res[c], (c == 6 || c == 10));
            chk($sformatf("wrap wen c%0d", c), cap_wen[c], (c == 9 || c == 13) ? 16'h8001 : 16'h0);
            chk($sformatf("wrap done c%0d", c), cap_done[c], (c >= 14));
         end
         chk("wrap waddr first", cap_wa[9], 9'h1FF);
         chk("wrap waddr second", cap_wa[13], 9'h000);
      end

      // Mid-run reset while strobes are active
      set_cfg(16'd2, 16'd3, 3'd3, 10'h10, 10'h20, 9'd5, 16'hFFFF, 1'b0);
      @(negedge clk);
      run = 1'b1;
      capture(3, 0, 0);
      chk("midrst pre en", vread_enB, 1'b1);
      chk("midrst pre ld_acc", ld_acc, 1'b1);
      #1 rst = 1'b0;
      #1 check_idle_outputs("midrst");
      #1 rst = 1'b1;
      @(negedge clk);
      set_cfg(16'd1, 16'd2, 3'd2, 10'h40, 10'h8, 9'd7, 16'h00F0, 1'b0);
      run = 1'b1;
      capture(10, 0, 0);
      for (int c = 1; c <= 10; c++) begin
         chk($sformatf("post en c%0d", c), cap_en[c], (c <= 2));
         if (c <= 2) chk($sformatf("post raddr c%0d", c), cap_ra[c], 10'h40 + 10'(c - 1));
         chk($sformatf("post ld_acc c%0d", c), cap_acc[c], (c == 3));
         chk($sformatf("post ld_res c%0d", c), cap_res[c], (c == 4));
         if (c == 3 || c == 4) chk($sformatf("post ld_nmac c%0d", c), cap_nmac[c], (c == 4) ? 2 : 7);
         chk($sformatf("post wen c%0d", c), cap_wen[c], (c == 7) ? 16'h00F0 : 16'h0);
         chk($sformatf("post done c%0d", c), cap_done[c], (c >= 8));
      end
      chk("post waddr", cap_wa[7], 9'd7);

      // Runs during ISSUE (edge 3) and FLUSH (edge 9) must be ignored
      set_cfg(16'd2, 16'd3, 3'd3, 10'h10, 10'h20, 9'd5, 16'hFFFF, 1'b0);
      @(negedge clk);
      run = 1'b1;
      capture(14, 3, 9);
      check_basic("busy");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
